// File: rtl/main_sequence_controller.sv
// Multi-cycle MIPS main control FSM: walks the shared datapath through
// fetch/decode/execute/memory/write-back and decodes datapath controls from the state.
module main_sequence_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               Mem_Ready,
    output logic               PC_Write,
    output logic               IorD,
    output logic               Mem_Read,
    output logic               Mem_Write,
    output logic               IR_Write,
    output logic [1:0]         Reg_Dst,
    output logic [1:0]         Mem_to_Reg,
    output logic               Reg_Write,
    output logic               ALU_Src_A,
    output logic [1:0]         ALU_Src_B,
    output logic               Ext_Sel,
    output logic [1:0]         PC_Source,
    output logic [2:0]         ALU_OP,
    output logic               Illegal_Op,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB,
        S_MEM_WRITE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH,
        S_JUMP, S_JAL, S_JR, S_ILLEGAL
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    state_t     r_state;
    logic       w_is_jr;
    logic       w_is_jalr;
    logic [2:0] w_i_alu_op;
    logic       w_i_ext;

    assign w_is_jalr = (Opcode == OP_RTYPE) && (Funct == FN_JALR);
    assign w_is_jr   = (Opcode == OP_RTYPE) && ((Funct == FN_JR) || (Funct == FN_JALR));
    assign State     = r_state;

    // Immediate ALU function and extension mode, shared by I_EXEC and I_WB
    always_comb begin
        w_i_alu_op = 3'b000;
        w_i_ext    = 1'b0;
        case (Opcode)
            OP_SLTI: w_i_alu_op = 3'b011;
            OP_ANDI: begin w_i_alu_op = 3'b100; w_i_ext = 1'b1; end
            OP_ORI:  begin w_i_alu_op = 3'b101; w_i_ext = 1'b1; end
            OP_XORI: begin w_i_alu_op = 3'b110; w_i_ext = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
        end else begin
            case (r_state)
                S_RESET:     r_state <= S_FETCH;
                S_FETCH:     r_state <= Mem_Ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (Opcode)
                        OP_RTYPE:        r_state <= w_is_jr ? S_JR : S_R_EXEC;
                        OP_LW, OP_SW:    r_state <= S_MEM_ADDR;
                        OP_BEQ, OP_BNE:  r_state <= S_BRANCH;
                        OP_J:            r_state <= S_JUMP;
                        OP_JAL:          r_state <= S_JAL;
                        OP_ADDI, OP_ADDIU, OP_SLTI,
                        OP_ANDI, OP_ORI, OP_XORI: r_state <= S_I_EXEC;
                        default:         r_state <= S_ILLEGAL;
                    endcase
                end
                S_MEM_ADDR:  r_state <= (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  r_state <= Mem_Ready ? S_MEM_WB : S_MEM_READ;
                S_MEM_WRITE: r_state <= Mem_Ready ? S_FETCH : S_MEM_WRITE;
                S_R_EXEC:    r_state <= S_R_WB;
                S_I_EXEC:    r_state <= S_I_WB;
                S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH,
                S_JUMP, S_JAL, S_JR, S_ILLEGAL: r_state <= S_FETCH;
                default:     r_state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        PC_Write   = 1'b0;
        IorD       = 1'b0;
        Mem_Read   = 1'b0;
        Mem_Write  = 1'b0;
        IR_Write   = 1'b0;
        Reg_Dst    = 2'b00;
        Mem_to_Reg = 2'b00;
        Reg_Write  = 1'b0;
        ALU_Src_A  = 1'b0;
        ALU_Src_B  = 2'b00;
        Ext_Sel    = 1'b0;
        PC_Source  = 2'b00;
        ALU_OP     = 3'b000;
        Illegal_Op = 1'b0;
        case (r_state)
            S_FETCH: begin
                Mem_Read  = 1'b1;
                ALU_Src_B = 2'b01;
                IR_Write  = Mem_Ready;
                PC_Write  = Mem_Ready;
            end
            // Branch target is precomputed into ALUOut while the register file is read
            S_DECODE:    ALU_Src_B = 2'b11;
            S_MEM_ADDR: begin
                ALU_Src_A = 1'b1;
                ALU_Src_B = 2'b10;
            end
            S_MEM_READ: begin
                IorD     = 1'b1;
                Mem_Read = 1'b1;
            end
            S_MEM_WB: begin
                Mem_to_Reg = 2'b01;
                Reg_Write  = 1'b1;
            end
            S_MEM_WRITE: begin
                IorD      = 1'b1;
                Mem_Write = 1'b1;
            end
            S_R_EXEC: begin
                ALU_Src_A = 1'b1;
                ALU_OP    = 3'b010;
            end
            S_R_WB: begin
                Reg_Dst   = 2'b01;
                Reg_Write = 1'b1;
            end
            S_I_EXEC: begin
                ALU_Src_A = 1'b1;
                ALU_Src_B = 2'b10;
                ALU_OP    = w_i_alu_op;
                Ext_Sel   = w_i_ext;
            end
            S_I_WB: begin
                Reg_Write = 1'b1;
                ALU_OP    = w_i_alu_op;
                Ext_Sel   = w_i_ext;
            end
            S_BRANCH: begin
                ALU_Src_A = 1'b1;
                ALU_OP    = 3'b001;
                PC_Source = 2'b01;
                PC_Write  = ((Opcode == OP_BEQ) && Zero) || ((Opcode == OP_BNE) && !Zero);
            end
            S_JUMP: begin
                PC_Write  = 1'b1;
                PC_Source = 2'b10;
            end
            S_JAL: begin
                PC_Write   = 1'b1;
                PC_Source  = 2'b10;
                Reg_Write  = 1'b1;
                Reg_Dst    = 2'b10;
                Mem_to_Reg = 2'b10;
            end
            S_JR: begin
                PC_Write  = 1'b1;
                PC_Source = 2'b11;
                if (w_is_jalr) begin
                    Reg_Write  = 1'b1;
                    Reg_Dst    = 2'b01;
                    Mem_to_Reg = 2'b10;
                end
            end
            S_ILLEGAL:   Illegal_Op = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_main_sequence_controller.sv
// Scoreboard bench: the driver expands each instruction into its per-cycle
// control vectors; a negedge monitor pops and compares them against the DUT.
module tb_main_sequence_controller;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_sel;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctl_t;

    typedef enum int {C_R, C_JR, C_JALR, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_I, C_ILL} cls_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] Opcode = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero = 1'b0;
    logic       Mem_Ready = 1'b0;
    logic       PC_Write, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Write;
    logic       ALU_Src_A, Ext_Sel, Illegal_Op;
    logic [1:0] Reg_Dst, Mem_to_Reg, ALU_Src_B, PC_Source;
    logic [2:0] ALU_OP;
    logic [3:0] State;
    ctl_t       act;

    ctl_t  exp_q[$];
    string nm_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    logic [5:0] legal_ops [13] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                   6'b000010, 6'b000011, 6'b001000, 6'b001001, 6'b001010,
                                   6'b001100, 6'b001101, 6'b001110};

    main_sequence_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .Mem_Ready(Mem_Ready), .PC_Write(PC_Write), .IorD(IorD), .Mem_Read(Mem_Read),
        .Mem_Write(Mem_Write), .IR_Write(IR_Write), .Reg_Dst(Reg_Dst),
        .Mem_to_Reg(Mem_to_Reg), .Reg_Write(Reg_Write), .ALU_Src_A(ALU_Src_A),
        .ALU_Src_B(ALU_Src_B), .Ext_Sel(Ext_Sel), .PC_Source(PC_Source),
        .ALU_OP(ALU_OP), .Illegal_Op(Illegal_Op), .State(State)
    );

    assign act = {PC_Write, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg,
                  Reg_Write, ALU_Src_A, ALU_Src_B, Ext_Sel, PC_Source, ALU_OP, Illegal_Op};

    always #5 clk = ~clk;

    task automatic compare(input ctl_t e, input string nm);
        n_vec++;
        if (act !== e || $isunknown(State)) begin
            n_err++;
            $display("FAIL %s: got %h (state %h) expected %h", nm, act, State, e);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) compare(exp_q.pop_front(), nm_q.pop_front());
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input ctl_t e, input logic mr, input logic z, input string nm);
        Mem_Ready = mr;
        Zero      = z;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; asserts reset mid-cycle and expects an immediate all-zero output.
    task automatic do_reset();
        ctl_t z;
        z = '0;
        #2 rst_n = 1'b0;
        #1 compare(z, "async_reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(z, rb(), rb(), "reset_cycle");
    endtask

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b001000) ? C_JR : (fn == 6'b001001) ? C_JALR : C_R;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000101: return C_BNE;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001110: return C_I;
            default:   return C_ILL;
        endcase
    endfunction

    task automatic do_fetch(input int fs);
        ctl_t e;
        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
        for (int i = 0; i < fs; i++) step(e, 1'b0, rb(), "fetch_wait");
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(e, 1'b1, rb(), "fetch");
        e = '0; e.alu_src_b = 2'b11;
        step(e, rb(), rb(), "decode");
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fs, input int ms);
        ctl_t e;
        cls_t c;
        Opcode = op;
        Funct  = fn;
        c      = classify(op, fn);
        do_fetch(fs);
        e = '0;
        case (c)
            C_R: begin
                e.alu_src_a = 1'b1; e.alu_op = 3'b010;
                step(e, rb(), rb(), "r_exec");
                e = '0; e.reg_dst = 2'b01; e.reg_write = 1'b1;
                step(e, rb(), rb(), "r_wb");
            end
            C_I: begin
                case (op)
                    6'b001010: e.alu_op = 3'b011;
                    6'b001100: begin e.alu_op = 3'b100; e.ext_sel = 1'b1; end
                    6'b001101: begin e.alu_op = 3'b101; e.ext_sel = 1'b1; end
                    6'b001110: begin e.alu_op = 3'b110; e.ext_sel = 1'b1; end
                    default:   e.alu_op = 3'b000;
                endcase
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                step(e, rb(), rb(), "i_exec");
                e.alu_src_a = 1'b0; e.alu_src_b = 2'b00; e.reg_write = 1'b1;
                step(e, rb(), rb(), "i_wb");
            end
            C_LW, C_SW: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                step(e, rb(), rb(), "mem_addr");
                e = '0; e.iord = 1'b1;
                if (c == C_LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
                for (int i = 0; i < ms; i++) step(e, 1'b0, rb(), "mem_wait");
                step(e, 1'b1, rb(), (c == C_LW) ? "mem_read" : "mem_write");
                if (c == C_LW) begin
                    e = '0; e.mem_to_reg = 2'b01; e.reg_write = 1'b1;
                    step(e, rb(), rb(), "mem_wb");
                end
            end
            C_BEQ, C_BNE: begin
                e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_source = 2'b01;
                e.pc_write  = (c == C_BEQ) ? z : ~z;
                step(e, rb(), z, (c == C_BEQ) ? "beq" : "bne");
            end
            C_J: begin
                e.pc_write = 1'b1; e.pc_source = 2'b10;
                step(e, rb(), rb(), "jump");
            end
            C_JAL: begin
                e.pc_write = 1'b1; e.pc_source = 2'b10;
                e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
                step(e, rb(), rb(), "jal");
            end
            C_JR, C_JALR: begin
                e.pc_write = 1'b1; e.pc_source = 2'b11;
                if (c == C_JALR) begin
                    e.reg_write = 1'b1; e.reg_dst = 2'b01; e.mem_to_reg = 2'b10;
                end
                step(e, rb(), rb(), (c == C_JALR) ? "jalr" : "jr");
            end
            default: begin
                e.illegal_op = 1'b1;
                step(e, rb(), rb(), "illegal");
            end
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        ctl_t       e;
        @(posedge clk); #1;
        do_reset();
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);   // add
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 2);   // lw, two wait cycles
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);   // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);   // beq not taken
        run_instr(6'b000101, 6'b000000, 1'b0, 0, 0);   // bne taken
        run_instr(6'b000101, 6'b000000, 1'b1, 0, 0);   // bne not taken
        run_instr(6'b001101, 6'b000000, 1'b0, 0, 0);   // ori
        run_instr(6'b001010, 6'b000000, 1'b0, 1, 0);   // slti
        run_instr(6'b000011, 6'b000000, 1'b0, 0, 0);   // jal
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);   // illegal
        run_instr(6'b000000, 6'b001000, 1'b0, 0, 0);   // jr
        run_instr(6'b000000, 6'b001001, 1'b0, 0, 0);   // jalr
        run_instr(6'b101011, 6'b000000, 1'b0, 2, 1);   // sw
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);   // j

        // sw abandoned by reset while its store strobe is up
        Opcode = 6'b101011; Funct = 6'd0;
        do_fetch(0);
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        step(e, 1'b0, rb(), "mem_addr");
        do_reset();

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 12)];
            else op = 6'($urandom);
            fn = 6'($urandom);
            if (op == 6'b000000 && $urandom_range(0, 3) == 0) fn = 6'b001000 | 6'(rb());
            run_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        @(posedge clk); #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/main_sequence_controller.md
Name: main_sequence_controller

Overview:
Multi-cycle MIPS main control FSM. It sequences the shared datapath through fetch, decode, execute, memory and write-back for each instruction. It drives the 3-bit ALU_OP field consumed by the ALU controller, plus all datapath mux, write-enable and memory strobes. It sits between the instruction register (Opcode/Funct), the ALU Zero flag and the memory ready handshake.

Parameters:
STATE_W, 4, width of the state register and of the State debug output

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
Opcode  in  6  IR[31:26]
Funct  in  6  IR[5:0]; used only to detect jr/jalr
Zero  in  1  ALU zero flag
Mem_Ready  in  1  memory access complete this cycle
PC_Write  out  1  PC load enable (already includes the branch condition)
IorD  out  1  0 = PC address, 1 = ALUOut address
Mem_Read  out  1  memory read strobe
Mem_Write  out  1  memory write strobe
IR_Write  out  1  instruction register load
Reg_Dst  out  2  00 = rt, 01 = rd, 10 = $31
Mem_to_Reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
Reg_Write  out  1  register file write enable
ALU_Src_A  out  1  0 = PC, 1 = A
ALU_Src_B  out  2  00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
Ext_Sel  out  1  0 = sign-extend, 1 = zero-extend
PC_Source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A
ALU_OP  out  3  000 add, 001 sub, 010 R-type(funct), 011 slt, 100 and, 101 or, 110 xor
Illegal_Op  out  1  one-cycle pulse on unsupported opcode
State  out  STATE_W  current state (debug)

Behaviour:
- Moore outputs: combinational decode of the registered state. PC_Write, IR_Write and the branch term also depend on inputs, as listed below. Every output is 0 unless listed for the state.
- rst_n low: state = RESET immediately (async), so all outputs are 0. RESET lasts exactly 1 cycle after rst_n deasserts, then goes to FETCH. Reset mid-instruction abandons it with no partial write.
- FETCH: Mem_Read=1, ALU_Src_B=01, ALU_OP=000, PC_Source=00; IR_Write = PC_Write = Mem_Ready. Hold in FETCH while Mem_Ready=0; go to DECODE when it is 1.
- DECODE: ALU_Src_B=11, ALU_OP=000 (branch target into ALUOut). Next state by opcode:
  - 000000 with Funct 001000/001001 -> JR; other 000000 -> R_EXEC.
  - 100011 -> MEM_ADDR (lw); 101011 -> MEM_ADDR (sw).
  - 000100/000101 -> BRANCH.
  - 000010 -> JUMP; 000011 -> JAL.
  - 001000/001001/001010/001100/001101/001110 -> I_EXEC.
  - anything else -> ILLEGAL.
- MEM_ADDR: ALU_Src_A=1, ALU_Src_B=10, Ext_Sel=0, ALU_OP=000. Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: IorD=1, Mem_Read=1. Hold until Mem_Ready, then MEM_WB.
- MEM_WB: Reg_Dst=00, Mem_to_Reg=01, Reg_Write=1 -> FETCH.
- MEM_WRITE: IorD=1, Mem_Write=1. Hold until Mem_Ready, then FETCH.
- R_EXEC: ALU_Src_A=1, ALU_Src_B=00, ALU_OP=010 -> R_WB.
- R_WB: Reg_Dst=01, Mem_to_Reg=00, Reg_Write=1 -> FETCH.
- I_EXEC: ALU_Src_A=1, ALU_Src_B=10 -> I_WB.
  - ALU_OP: addi/addiu 000, slti 011, andi 100, ori 101, xori 110.
  - Ext_Sel=1 for andi/ori/xori, else 0.
- I_WB: Reg_Dst=00, Mem_to_Reg=00, Reg_Write=1. Ext_Sel and ALU_OP held as in I_EXEC -> FETCH.
- BRANCH: ALU_Src_A=1, ALU_Src_B=00, ALU_OP=001, PC_Source=01 -> FETCH.
  - PC_Write = (beq & Zero) | (bne & ~Zero).
- JUMP: PC_Write=1, PC_Source=10 -> FETCH.
- JAL: PC_Write=1, PC_Source=10, Reg_Write=1, Reg_Dst=10, Mem_to_Reg=10 -> FETCH.
- JR: PC_Write=1, PC_Source=11 -> FETCH.
  - jalr additionally drives Reg_Write=1, Reg_Dst=01, Mem_to_Reg=10.
- ILLEGAL: Illegal_Op=1 for 1 cycle -> FETCH (instruction executes as a NOP).
- Opcode/Funct are sampled combinationally every state; the IR holds them stable after FETCH.
- Unused state encodings go to RESET.
- Latency with Mem_Ready=1: R/I/branch/jump 3-4 cycles; lw 5; sw 4.

Test Plan:
- Assert rst_n=0 mid-cycle -> all outputs 0 at once; after release: 1 cycle RESET, then FETCH with Mem_Read=1, State=FETCH.
- add (Opcode 000000, Funct 100000), Mem_Ready=1 -> FETCH, DECODE, R_EXEC (ALU_OP=010), R_WB (Reg_Write=1, Reg_Dst=01) -> FETCH; exactly 4 cycles.
- lw (100011) with Mem_Ready=0 for 2 cycles in MEM_READ -> MEM_READ held 3 cycles, then MEM_WB with Mem_to_Reg=01 -> total 7 cycles.
- beq (000100):
  - Zero=1 -> PC_Write=1, PC_Source=01 in BRANCH.
  - Zero=0 -> PC_Write=0.
  - bne with Zero=0 -> PC_Write=1.
- ori (001101) -> I_EXEC with ALU_OP=101, Ext_Sel=1; I_WB with Reg_Dst=00.
- jal (000011) -> JAL state: PC_Write=1, Reg_Dst=10, Mem_to_Reg=10. Opcode 111111 -> Illegal_Op pulses 1 cycle, no Reg_Write/Mem_Write, returns to FETCH.
